i2c_slave_responder: RTL

I2C_SLAVE_RESPONDER -- requirements
Module: i2c_slave_responder

---
 rtl/i2c_pkg.sv | 17 +
 rtl/i2c_sync_edge.sv | 31 +++
 rtl/i2c_slave_responder.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C slave responder: address width and FSM state encoding.
package i2c_pkg;

  localparam int I2C_ADDR_W = 7;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    WAIT_STOP
  } i2c_state_t;

endpackage

// File: rtl/i2c_sync_edge.sv
// Multi-flop synchronizer for one bus line plus rise/fall strobes on the synchronized value.
// Flops reset to 1 so a freshly reset block sees an idle (pulled-up) bus.
module i2c_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign q_o    = sync_q[STAGES-1];
  assign rise_o = sync_q[STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/i2c_slave_responder.sv
// 7-bit address I2C slave: receives written bytes, requests and shifts out read bytes.
//
// state     | meaning
// IDLE      | bus free or after reset, waiting for START
// ADDR      | shifting in address + R/W bit
// ADDR_ACK  | driving ACK for a matched address
// WR_DATA   | shifting in a byte from the master
// WR_ACK    | driving ACK for a received byte
// RD_DATA   | shifting a byte out to the master
// RD_ACK    | sampling the master's ACK/NACK
// WAIT_STOP | not addressed or read ended, ignore bus until START/STOP
module i2c_slave_responder
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] SLV_ADDR    = 7'h50,
  parameter int                    SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_first,
  output logic       tx_req,
  input  logic [7:0] tx_data,
  output logic       busy
);

  logic scl_s, scl_rise, scl_fall;
  logic sda_s, sda_rise, sda_fall;
  logic start_det, stop_det;

  i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_scl_sync (
    .clk(clk), .rst(rst), .d_i(scl_i), .q_o(scl_s), .rise_o(scl_rise), .fall_o(scl_fall)
  );

  i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_sda_sync (
    .clk(clk), .rst(rst), .d_i(sda_i), .q_o(sda_s), .rise_o(sda_rise), .fall_o(sda_fall)
  );

  assign start_det = sda_fall & scl_s;
  assign stop_det  = sda_rise & scl_s;

  i2c_state_t state_q;
  logic [2:0] bit_cnt_q;
  logic [6:0] shift_q;
  logic [6:0] tx_shift_q;
  logic       rw_q, first_q, nack_q;
  logic       sda_oe_q, rx_valid_q, rx_first_q, tx_req_q, busy_q;
  logic [7:0] rx_data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tx_shift_q <= '0;
      rw_q       <= 1'b0;
      first_q    <= 1'b0;
      nack_q     <= 1'b0;
      sda_oe_q   <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      rx_first_q <= 1'b0;
      tx_req_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      rx_first_q <= 1'b0;
      tx_req_q   <= 1'b0;
      if (stop_det) begin
        state_q  <= IDLE;
        busy_q   <= 1'b0;
        sda_oe_q <= 1'b0;
      end else if (start_det) begin
        state_q   <= ADDR;
        bit_cnt_q <= '0;
        busy_q    <= 1'b1;
        sda_oe_q  <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE, WAIT_STOP: ;
          ADDR: if (scl_rise) begin
            shift_q   <= {shift_q[5:0], sda_s};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              rw_q    <= sda_s;
              state_q <= (shift_q == SLV_ADDR) ? ADDR_ACK : WAIT_STOP;
            end
          end
          // sda_oe doubles as the ACK phase: first fall drives, second fall releases.
          ADDR_ACK: if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_q <= 1'b1;
            end else begin
              sda_oe_q <= 1'b0;
              if (rw_q) begin
                state_q  <= RD_DATA;
                tx_req_q <= 1'b1;
              end else begin
                state_q <= WR_DATA;
                first_q <= 1'b1;
              end
            end
          end
          WR_DATA: if (scl_rise) begin
            shift_q   <= {shift_q[5:0], sda_s};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              rx_data_q  <= {shift_q, sda_s};
              rx_valid_q <= 1'b1;
              rx_first_q <= first_q;
              first_q    <= 1'b0;
              state_q    <= WR_ACK;
            end
          end
          WR_ACK: if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_q <= 1'b1;
            end else begin
              sda_oe_q <= 1'b0;
              state_q  <= WR_DATA;
            end
          end
          // tx_data is captured while tx_req is high, one clk after the SCL fall.
          RD_DATA: begin
            if (tx_req_q) begin
              tx_shift_q <= tx_data[6:0];
              sda_oe_q   <= ~tx_data[7];
              bit_cnt_q  <= '0;
            end else if (scl_rise) begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end else if (scl_fall) begin
              if (bit_cnt_q == 3'd0) begin
                sda_oe_q <= 1'b0;
                state_q  <= RD_ACK;
              end else begin
                sda_oe_q   <= ~tx_shift_q[6];
                tx_shift_q <= {tx_shift_q[5:0], 1'b0};
              end
            end
          end
          RD_ACK: begin
            if (scl_rise) begin
              nack_q <= sda_s;
            end else if (scl_fall) begin
              if (!nack_q) begin
                state_q  <= RD_DATA;
                tx_req_q <= 1'b1;
              end else begin
                state_q <= WAIT_STOP;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign sda_oe   = sda_oe_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign rx_first = rx_first_q;
  assign tx_req   = tx_req_q;
  assign busy     = busy_q;

endmodule
